// File: rtl/dmem_pkg.sv
// Shared constants, port identifiers and the address range check for the
// data-memory arbiter.
package dmem_pkg;

  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned WORD_WIDTH = 32;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  // A word access is legal only if all four bytes fall inside the memory.
  function automatic logic in_range(input logic [WORD_WIDTH-1:0] addr,
                                    input int unsigned            depth);
    return (addr <= WORD_WIDTH'(depth - 32'd4));
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant logic: round-robin or fixed priority to port 0, with a
// starvation guard that forces a port-1 grant in fixed-priority mode.
module rr_arbiter2 #(
  parameter bit          RR_MODE      = 1'b1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);
  import dmem_pkg::*;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  port_e      last_gnt_r;
  logic [7:0] starve_cnt_r;
  logic [7:0] starve_cnt_nxt_s;
  logic       force_s;

  // Grant selection: forced port 1 first, then single requester, then tie-break
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    force_s = (RR_MODE == 1'b0) && (starve_cnt_r == LIMIT) && req1;
    if (force_s) begin
      gnt1 = 1'b1;
    end else if (req0 && !req1) begin
      gnt0 = 1'b1;
    end else if (req1 && !req0) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      if (RR_MODE && (last_gnt_r == PORT_CPU)) begin
        gnt1 = 1'b1;
      end else begin
        gnt0 = 1'b1;
      end
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Starvation counter: counts port-1 waiting cycles, saturating at the limit
  always_comb begin
    starve_cnt_nxt_s = 8'd0;
    if (req1 && !gnt1) begin
      if (starve_cnt_r >= LIMIT) begin
        starve_cnt_nxt_s = LIMIT;
      end else begin
        starve_cnt_nxt_s = starve_cnt_r + 8'd1;
      end
    end else begin
      starve_cnt_nxt_s = 8'd0;
    end
  end

  // Arbitration state; last_gnt resets to port 1 so port 0 wins the first tie
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_gnt_r   <= PORT_DMA;
      starve_cnt_r <= 8'd0;
    end else begin
      if (gnt0) begin
        last_gnt_r <= PORT_CPU;
      end else if (gnt1) begin
        last_gnt_r <= PORT_DMA;
      end else begin
        last_gnt_r <= last_gnt_r;
      end
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Shares the single-ported big-endian data memory between the CPU load/store
// path (port 0) and the DMA/debug loader (port 1), one access per cycle.
module datamem_arbiter #(
  parameter int unsigned MEM_DEPTH    = dmem_pkg::MEM_DEPTH,
  parameter int unsigned WORD_WIDTH   = dmem_pkg::WORD_WIDTH,
  parameter bit          RR_MODE      = 1'b1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic [WORD_WIDTH-1:0] p0_addr,
  input  logic [WORD_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [WORD_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [WORD_WIDTH-1:0] p1_addr,
  input  logic [WORD_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [WORD_WIDTH-1:0] p1_rdata,
  output logic                  p1_err,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata
);
  import dmem_pkg::*;

  logic                  gnt0_s;
  logic                  gnt1_s;
  logic                  any_gnt_s;
  port_e                 sel_port_s;
  logic                  sel_wr_s;
  logic                  sel_in_range_s;
  logic [WORD_WIDTH-1:0] sel_addr_s;
  logic [WORD_WIDTH-1:0] sel_wdata_s;
  logic [WORD_WIDTH-1:0] addr_hold_r;
  logic [WORD_WIDTH-1:0] wdata_hold_r;
  logic                  rsp_pend_r;
  port_e                 rsp_port_r;
  logic                  rsp_err_r;

  rr_arbiter2 #(
    .RR_MODE      (RR_MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk  (clk),
    .nrst (nrst),
    .req0 (p0_req),
    .req1 (p1_req),
    .gnt0 (gnt0_s),
    .gnt1 (gnt1_s)
  );

  assign p0_gnt = gnt0_s;
  assign p1_gnt = gnt1_s;

  // Memory mux: granted port drives the pins; idle cycles hold the address
  always_comb begin
    any_gnt_s = gnt0_s | gnt1_s;
    if (gnt1_s) begin
      sel_port_s  = PORT_DMA;
      sel_wr_s    = p1_wr;
      sel_addr_s  = p1_addr;
      sel_wdata_s = p1_wdata;
    end else begin
      sel_port_s  = PORT_CPU;
      sel_wr_s    = p0_wr;
      sel_addr_s  = p0_addr;
      sel_wdata_s = p0_wdata;
    end
    sel_in_range_s = in_range(sel_addr_s, MEM_DEPTH);
    if (any_gnt_s) begin
      mem_addr  = sel_addr_s;
      mem_wdata = sel_wdata_s;
      mem_wr    = sel_wr_s & sel_in_range_s;
    end else begin
      mem_addr  = addr_hold_r;
      mem_wdata = wdata_hold_r;
      mem_wr    = 1'b0;
    end
  end

  // Held memory address/data and the one-deep response pipeline
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_hold_r  <= {WORD_WIDTH{1'b0}};
      wdata_hold_r <= {WORD_WIDTH{1'b0}};
      rsp_pend_r   <= 1'b0;
      rsp_port_r   <= PORT_CPU;
      rsp_err_r    <= 1'b0;
    end else begin
      if (any_gnt_s) begin
        addr_hold_r  <= sel_addr_s;
        wdata_hold_r <= sel_wdata_s;
      end else begin
        addr_hold_r  <= addr_hold_r;
        wdata_hold_r <= wdata_hold_r;
      end
      // Reads always answer; writes answer only to report a range error
      rsp_pend_r <= any_gnt_s & (~sel_wr_s | ~sel_in_range_s);
      rsp_port_r <= sel_port_s;
      rsp_err_r  <= any_gnt_s & ~sel_in_range_s;
    end
  end

  // Response steering; the non-responding port stays quiet with zero data
  always_comb begin
    p0_rvalid = rsp_pend_r && (rsp_port_r == PORT_CPU);
    p1_rvalid = rsp_pend_r && (rsp_port_r == PORT_DMA);
    p0_err    = p0_rvalid & rsp_err_r;
    p1_err    = p1_rvalid & rsp_err_r;
    if (p0_rvalid && !rsp_err_r) begin
      p0_rdata = mem_rdata;
    end else begin
      p0_rdata = {WORD_WIDTH{1'b0}};
    end
    if (p1_rvalid && !rsp_err_r) begin
      p1_rdata = mem_rdata;
    end else begin
      p1_rdata = {WORD_WIDTH{1'b0}};
    end
  end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single-ported, byte-addressed, big-endian data memory (1024 x 8, 32-bit word access, synchronous read, synchronous write) between two requesters.
  - Port 0 is the processor load/store path.
  - Port 1 is the DMA/debug loader.
- One access is granted per cycle, with registered read responses and a starvation guard for port 1.
- The block sits between both requesters and the memory's clk/data_addr/data_wr/data_out/data_in pins.

Parameters:
- MEM_DEPTH, 1024, memory size in bytes; legal word access requires addr <= MEM_DEPTH-4.
- WORD_WIDTH, 32, data/address width.
- RR_MODE, 1, 1 = round-robin between ports; 0 = fixed priority to port 0.
- STARVE_LIMIT, 8, in fixed-priority mode, consecutive cycles port 1 may wait before it is forced a grant (range 1..255).

Ports:
- clk  in  1  single clock; all state on rising edge.
- nrst  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 access request.
- p0_wr  in  1  port 0 write (1) / read (0).
- p0_addr  in  32  port 0 byte address.
- p0_wdata  in  32  port 0 store data.
- p0_gnt  out  1  port 0 granted this cycle (combinational).
- p0_rvalid  out  1  port 0 read/err response valid.
- p0_rdata  out  32  port 0 read data.
- p0_err  out  1  port 0 response is out-of-range error.
- p1_req, p1_wr, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1.
- mem_addr  out  32  to data_addr.
- mem_wr  out  1  to data_wr.
- mem_wdata  out  32  to data_out (processor-to-memory).
- mem_rdata  in  32  from data_in (memory-to-processor).

Behaviour:
- Reset (nrst low, asynchronous):
  - last_gnt = port 1, so port 0 wins the first tie.
  - starve_cnt = 0.
  - rsp_pend = 0.
  - All rvalid/err outputs 0; rdata outputs 0.
- Handshake:
  - A request is accepted in the cycle where req=1 and gnt=1.
  - The requester must hold req/wr/addr/wdata stable until gnt.
  - gnt is never asserted without req.
  - At most one gnt per cycle.
- Arbitration (combinational grant, registered state), by priority:
  1. Forced: if RR_MODE=0, starve_cnt == STARVE_LIMIT and p1_req, then p1_gnt.
  2. Only one port requesting: grant it.
  3. Both requesting, RR_MODE=1: grant the port != last_gnt.
  4. Both requesting, RR_MODE=0: grant port 0.
- last_gnt updates on every grant.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when p1_req=1 and p1_gnt=0.
  - Clears on p1_gnt, or when p1_req=0.
- Memory drive:
  - When a grant is issued, mem_addr/mem_wdata = the granted port's addr/wdata; mem_wr = granted wr AND in_range.
  - With no grant: mem_wr = 0 and mem_addr holds its last value (no spurious writes).
- Range check: in_range = (addr <= MEM_DEPTH-4). Out-of-range accesses are still granted, but:
  - Writes are suppressed.
  - A response is issued with err=1 for both reads and writes.
- Read latency:
  - A read granted in cycle N gives rvalid=1 on the granted port in cycle N+1, with rdata = mem_rdata sampled in N+1. The memory registers data at the edge ending N.
  - Writes produce no rvalid unless out of range (then rvalid=1, err=1 in N+1).
- Response tracking: rsp_pend (1 bit), rsp_port, rsp_err are registered at the grant edge; rvalid is a one-cycle pulse.
- Back-to-back:
  - Grants every cycle are allowed.
  - Read-after-write to the same address in consecutive cycles returns the old data (memory read and write share an edge). Requesters must not depend on forwarding.
- Non-responding port: rdata = 0 and rvalid = 0.
- Reset mid-operation: a pending response is dropped; the write granted in the reset cycle is not guaranteed.

Decomposition:
- Shared package dmem_pkg:
  - Constants MEM_DEPTH, WORD_WIDTH.
  - Port-id enum PORT_CPU=0, PORT_DMA=1.
  - Function in_range(addr).
- One sub-module, rr_arbiter2: the 2-way grant logic with last_gnt and starve_cnt.
- The top-level handles the memory mux and the response pipeline.

Test Plan:
1. After reset, p0 read at 0x10 where memory holds 0xDEADBEEF: p0_gnt same cycle; p0_rvalid=1 and p0_rdata=0xDEADBEEF next cycle; p1 outputs quiet.
2. RR_MODE=1, both requesting reads for 6 cycles: grants alternate p0,p1,p0,...; each rvalid lands on the correct port one cycle later.
3. RR_MODE=0, STARVE_LIMIT=3, p0 requesting continuously and p1 requesting: p1_gnt in the 4th cycle only; starve_cnt then returns to 0.
4. p1 write 0x11223344 at 0x3FC, then p0 read 0x3FC: bytes 0x3FC..0x3FF = 11,22,33,44; read returns 0x11223344.
5. p0 write at 0x3FD (out of range): mem_wr never asserted; next cycle p0_rvalid=1, p0_err=1; memory unchanged.
6. Assert nrst low between a read grant and its response cycle: no rvalid on either port; arbitration restarts with port 0 winning the tie.
